// File: rtl/pipe_skid_reg_if.sv
// Handshake bundle for pipe_skid_reg: upstream (in_*) and downstream (out_*) sides.
// A transfer happens on a side exactly in a cycle where its valid and ready are both 1 at posedge clk.
interface pipe_skid_reg_if #(
  parameter int DATA_W = 64
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_skid_reg.sv
// Two-entry skid pipeline register (main + skid) with flush, freeze and a saturating drop counter.
// in_ready depends only on state and freeze, so there is no combinational path from out_ready.
module pipe_skid_reg #(
  parameter int              DATA_W = 64,
  parameter logic [DATA_W-1:0] BUBBLE = '0,
  parameter int              CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  pipe_skid_reg_if.slave   bus,
  input  logic             flush,
  input  logic             freeze,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] drop_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam int SUM_W = CNT_W + 2;
  localparam logic [SUM_W-1:0] CNT_MAX = {2'b00, {CNT_W{1'b1}}};

  state_t            state;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;
  logic              accept;
  logic              rel;
  logic [SUM_W-1:0]  drop_now;
  logic [SUM_W-1:0]  drop_sum;
  logic [CNT_W-1:0]  drop_next;

  assign bus.in_ready  = ~freeze & (state != FULL);
  assign bus.out_valid = ~freeze & (state != EMPTY);
  assign bus.out_data  = (state != EMPTY) ? main_q : BUBBLE;
  assign occupancy     = state;

  assign accept = bus.in_valid & bus.in_ready;
  assign rel    = bus.out_valid & bus.out_ready;

  // A head taken by downstream in the flush cycle is delivered, not dropped.
  always_comb begin
    drop_now  = {{(SUM_W-2){1'b0}}, state}
              - {{(SUM_W-1){1'b0}}, rel}
              + {{(SUM_W-1){1'b0}}, accept};
    drop_sum  = {2'b00, drop_cnt} + drop_now;
    drop_next = (drop_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : drop_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= EMPTY;
      main_q   <= BUBBLE;
      skid_q   <= BUBBLE;
      drop_cnt <= '0;
    end else if (!freeze) begin
      if (flush) begin
        state    <= EMPTY;
        main_q   <= BUBBLE;
        skid_q   <= BUBBLE;
        drop_cnt <= drop_next;
      end else begin
        case (state)
          EMPTY: begin
            if (accept) begin
              state  <= ONE;
              main_q <= bus.in_data;
            end
          end
          ONE: begin
            if (accept && rel) begin
              main_q <= bus.in_data;
            end else if (accept) begin
              state  <= FULL;
              skid_q <= bus.in_data;
            end else if (rel) begin
              state <= EMPTY;
            end
          end
          FULL: begin
            if (rel) begin
              state  <= ONE;
              main_q <= skid_q;
            end
          end
          default: state <= EMPTY;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: directed vector table, hand-written corner sequences,
// then randomized traffic checked against a queue-based FIFO model.
module tb_pipe_skid_reg;

  localparam int DW = 16;
  localparam int CW = 2;
  localparam logic [DW-1:0] BUB = 16'hDEAD;
  localparam int DROP_MAX = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  logic freeze = 1'b0;
  logic [1:0] occupancy;
  logic [CW-1:0] drop_cnt;

  always #5 clk = ~clk;

  pipe_skid_reg_if #(.DATA_W(DW)) bus ();

  pipe_skid_reg #(
    .DATA_W(DW),
    .BUBBLE(BUB),
    .CNT_W (CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .flush    (flush),
    .freeze   (freeze),
    .occupancy(occupancy),
    .drop_cnt (drop_cnt)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [DW-1:0] exp_q[$];
  int m_drop = 0;

  typedef struct {
    logic          iv;
    logic [DW-1:0] d;
    logic          ordy;
    logic          fl;
    logic          fz;
    logic          ir;
    logic          ov;
    logic [DW-1:0] od;
    logic [1:0]    occ;
    logic [1:0]    drop;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mkv(logic iv, logic [DW-1:0] d, logic ordy, logic fl, logic fz,
                               logic ir, logic ov, logic [DW-1:0] od, logic [1:0] occ,
                               logic [1:0] drop);
    vec_t v;
    v.iv = iv; v.d = d; v.ordy = ordy; v.fl = fl; v.fz = fz;
    v.ir = ir; v.ov = ov; v.od = od; v.occ = occ; v.drop = drop;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic iv, input logic [DW-1:0] d, input logic ordy,
                       input logic fl, input logic fz);
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = ordy;
    flush         = fl;
    freeze        = fz;
  endtask

  task automatic step(input logic iv, input logic [DW-1:0] d, input logic ordy,
                      input logic fl, input logic fz);
    drive(iv, d, ordy, fl, fz);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk(input string name, input logic ir, input logic ov,
                     input logic [DW-1:0] od, input logic [1:0] occ, input logic [1:0] drop);
    cmp({name, ".in_ready"},  {31'd0, bus.in_ready},  {31'd0, ir});
    cmp({name, ".out_valid"}, {31'd0, bus.out_valid}, {31'd0, ov});
    cmp({name, ".out_data"},  {16'd0, bus.out_data},  {16'd0, od});
    cmp({name, ".occupancy"}, {30'd0, occupancy},     {30'd0, occ});
    cmp({name, ".drop_cnt"},  {30'd0, drop_cnt},      {30'd0, drop});
  endtask

  // Reference: the stage is a FIFO of depth 2; flush drops whatever is still inside.
  task automatic model_step(input logic iv, input logic [DW-1:0] d, input logic ordy,
                            input logic fl, input logic fz);
    int sz;
    bit rl;
    bit ac;
    sz = exp_q.size();
    if (!fz) begin
      rl = ordy && (sz > 0);
      ac = iv && (sz < 2);
      if (fl) begin
        m_drop = m_drop + sz - int'(rl) + int'(ac);
        if (m_drop > DROP_MAX) m_drop = DROP_MAX;
        exp_q.delete();
      end else begin
        if (rl) void'(exp_q.pop_front());
        if (ac) exp_q.push_back(d);
      end
    end
  endtask

  // ---------------- test ----------------
  initial begin
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);

    vecs[0]  = mkv(1, 16'h0001, 1, 0, 0,  1, 0, BUB,      0, 0);
    vecs[1]  = mkv(1, 16'h0002, 1, 0, 0,  1, 1, 16'h0001, 1, 0);
    vecs[2]  = mkv(1, 16'h0003, 1, 0, 0,  1, 1, 16'h0002, 1, 0);
    vecs[3]  = mkv(1, 16'h0004, 1, 0, 0,  1, 1, 16'h0003, 1, 0);
    vecs[4]  = mkv(0, 16'h0000, 1, 0, 0,  1, 1, 16'h0004, 1, 0);
    vecs[5]  = mkv(0, 16'h0000, 0, 0, 0,  1, 0, BUB,      0, 0);
    vecs[6]  = mkv(1, 16'h000A, 0, 0, 0,  1, 0, BUB,      0, 0);
    vecs[7]  = mkv(1, 16'h000B, 0, 0, 0,  1, 1, 16'h000A, 1, 0);
    vecs[8]  = mkv(0, 16'h0000, 1, 0, 0,  0, 1, 16'h000A, 2, 0);
    vecs[9]  = mkv(0, 16'h0000, 1, 0, 0,  1, 1, 16'h000B, 1, 0);
    vecs[10] = mkv(0, 16'h0000, 0, 0, 0,  1, 0, BUB,      0, 0);
    // single-entry flush first, so the full-stage flush below lands the counter on 3
    vecs[11] = mkv(1, 16'h0011, 0, 0, 0,  1, 0, BUB,      0, 0);
    vecs[12] = mkv(0, 16'h0000, 0, 1, 0,  1, 1, 16'h0011, 1, 0);
    vecs[13] = mkv(1, 16'h00C1, 0, 0, 0,  1, 0, BUB,      0, 1);
    vecs[14] = mkv(1, 16'h00C2, 0, 0, 0,  1, 1, 16'h00C1, 1, 1);
    vecs[15] = mkv(1, 16'h00C3, 0, 1, 0,  0, 1, 16'h00C1, 2, 1);
    vecs[16] = mkv(0, 16'h0000, 0, 0, 0,  1, 0, BUB,      0, 3);

    // reset state, with and without freeze
    #3;
    chk("reset", 1, 0, BUB, 0, 0);
    freeze = 1'b1;
    #1;
    cmp("reset_freeze.in_ready", {31'd0, bus.in_ready}, 32'd0);
    freeze = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;

    // directed table: check outputs of the current cycle, then clock
    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].iv, vecs[i].d, vecs[i].ordy, vecs[i].fl, vecs[i].fz);
      #1;
      chk($sformatf("vec%0d", i), vecs[i].ir, vecs[i].ov, vecs[i].od, vecs[i].occ, vecs[i].drop);
      @(posedge clk);
      #1;
    end

    // flush of a full stage while downstream takes the head
    do_reset();
    step(1, 16'h0011, 0, 0, 0);
    step(0, 16'h0000, 0, 1, 0);
    step(1, 16'h00C1, 0, 0, 0);
    step(1, 16'h00C2, 0, 0, 0);
    chk("full_before_flush", 0, 1, 16'h00C1, 2, 1);
    step(1, 16'h00C3, 1, 1, 0);
    chk("flush_full_rel", 1, 0, BUB, 0, 2);

    // freeze beats flush and holds everything
    step(1, 16'h0055, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 16'h0077, 1, 1, 1);
      #1;
      chk($sformatf("freeze%0d", i), 0, 0, 16'h0055, 1, 2);
      @(posedge clk);
      #1;
    end
    drive(0, 16'h0000, 0, 0, 0);
    #1;
    chk("unfreeze", 1, 1, 16'h0055, 1, 2);

    // drop counter saturation
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      logic [DW-1:0] a;
      int exp_drop;
      a = DW'(k * 2);
      step(1, a, 0, 0, 0);
      step(1, a + 16'd1, 0, 0, 0);
      chk($sformatf("sat_full%0d", k), 0, 1, a, 2, 2'((2 * (k - 1) > DROP_MAX) ? DROP_MAX : 2 * (k - 1)));
      step(0, 16'h0000, 0, 1, 0);
      exp_drop = (2 * k > DROP_MAX) ? DROP_MAX : 2 * k;
      chk($sformatf("sat_flush%0d", k), 1, 0, BUB, 0, 2'(exp_drop));
    end

    // asynchronous reset while full and back-pressured
    step(1, 16'h00A0, 0, 0, 0);
    step(1, 16'h00B0, 0, 0, 0);
    chk("async_pre", 0, 1, 16'h00A0, 2, 3);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst", 1, 0, BUB, 0, 0);
    drive(0, '0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // randomized traffic against the FIFO model
    exp_q.delete();
    m_drop = 0;
    for (int c = 0; c < 600; c++) begin
      logic iv;
      logic [DW-1:0] d;
      logic ordy;
      logic fl;
      logic fz;
      int sz;
      iv   = 1'($urandom_range(0, 3) != 0);
      d    = DW'($urandom);
      ordy = 1'($urandom_range(0, 2) != 0);
      fl   = 1'($urandom_range(0, 11) == 0);
      fz   = 1'($urandom_range(0, 7) == 0);
      drive(iv, d, ordy, fl, fz);
      #1;
      sz = exp_q.size();
      chk($sformatf("rand%0d", c), !fz && (sz < 2), !fz && (sz > 0),
          (sz > 0) ? exp_q[0] : BUB, 2'(sz), 2'(m_drop));
      model_step(iv, d, ordy, fl, fz);
      @(posedge clk);
      #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter DATA_W, default 64, payload width (PC + instruction for the IF/ID use).
REQ-002 Parameter BUBBLE, default 0, DATA_W-bit value driven on out_data when no valid entry is held.
REQ-003 Parameter CNT_W, default 8, width of drop_cnt.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 rst  input  1  reset, asynchronous assertion, active-low (0 = reset).
REQ-006 in_valid  input  1  upstream offers in_data.
REQ-007 in_data  input  DATA_W  upstream payload.
REQ-008 in_ready  output  1  stage accepts in_data this cycle.
REQ-009 out_valid  output  1  out_data holds a valid entry.
REQ-010 out_data  output  DATA_W  head entry payload, or BUBBLE when empty.
REQ-011 out_ready  input  1  downstream accepts out_data this cycle.
REQ-012 flush  input  1  discard all held entries and the incoming one.
REQ-013 freeze  input  1  hold all state; no transfer on either side.
REQ-014 occupancy  output  2  number of held entries (0, 1 or 2).
REQ-015 drop_cnt  output  CNT_W  saturating count of valid entries discarded by flush.

Function
REQ-016 Storage: main register (head, drives out_data) plus one skid register; states EMPTY (0), ONE (1), FULL (2); occupancy equals state.
REQ-017 in_ready = ~freeze & (state != FULL); combinational from state and freeze only, never from out_ready.
REQ-018 out_valid = ~freeze & (state != EMPTY); out_data = main register when state != EMPTY, else BUBBLE.
REQ-019 Accept event: in_valid & in_ready; release event: out_valid & out_ready.
REQ-020 EMPTY: accept -> ONE, main <= in_data; no accept -> stay EMPTY.
REQ-021 ONE: accept and release -> stay ONE, main <= in_data; accept only -> FULL, skid <= in_data; release only -> EMPTY; neither -> hold.
REQ-022 FULL: release -> ONE, main <= skid; no release -> hold (in_ready = 0, so no accept).
REQ-023 Latency: an entry accepted in cycle N is visible on out_data with out_valid in cycle N+1 when the stage was EMPTY, or behind ONE older entry; zero-bubble throughput of 1 entry/cycle while out_ready stays 1.
REQ-024 Ordering strictly FIFO; no entry duplicated or lost except by flush.
REQ-025 Freeze: while freeze = 1, state, main, skid and drop_cnt hold; flush is ignored (freeze has priority over flush); in_valid/out_ready are don't-care.
REQ-026 Flush (freeze = 0): next state EMPTY; main and skid loaded with BUBBLE; in_data of the flush cycle is not captured; a release presented in the flush cycle still completes (downstream took the head).
REQ-027 drop_cnt on flush increments by (occupancy minus 1 if a release completed that cycle) plus 1 if in_valid & in_ready, saturating at 2^CNT_W-1; never wraps.
REQ-028 Payload is passed unmodified; no width conversion; out_data glitch-free (driven from registers and state only).

Reset
REQ-029 While rst = 0: state EMPTY, main = skid = BUBBLE, drop_cnt = 0, occupancy = 0, out_valid = 0, out_data = BUBBLE; in_ready = ~freeze.
REQ-030 Reset asserts asynchronously and overrides any in-flight transfer; entries held at assertion are lost and not counted in drop_cnt.
REQ-031 First transfer possible at the first posedge clk with rst = 1.

Verification
REQ-032 Streaming: out_ready = 1, in_valid = 1 with data 1,2,3,4 on consecutive cycles -> out_data 1,2,3,4 on the following consecutive cycles, occupancy stays 1, in_ready never 0.
REQ-033 Backpressure: push 0xA, 0xB with out_ready = 0 -> occupancy 2, in_ready = 0, out_data = 0xA; raise out_ready -> 0xA then 0xB on consecutive cycles, occupancy 2->1->0.
REQ-034 Flush in FULL with in_valid = 1, out_ready = 0 -> next cycle occupancy 0, out_valid = 0, out_data = BUBBLE, drop_cnt = 3; with out_ready = 1 in the flush cycle, drop_cnt = 2.
REQ-035 Freeze in ONE holding 0x55 with flush = 1, in_valid = 1 for 3 cycles -> in_ready = out_valid = 0, drop_cnt unchanged; after freeze drops, out_data = 0x55, out_valid = 1.
REQ-036 drop_cnt saturation with CNT_W = 2: four flushes of FULL stage -> drop_cnt = 3, no wrap.
REQ-037 Async reset mid-backpressure (FULL), rst = 0 between clock edges -> out_valid = 0, occupancy = 0, out_data = BUBBLE immediately, before the next edge.
